tdm_mux16: RTL

- 16-lane to 1 round-robin collecting multiplexer.
- Gathers DW-bit words from 16 independent lane sources onto one registered output stream, tagged with the source lane index.
- Return-path companion to the 1-to-16 select-addressed data distributor: lanes are the producers, the single output is the consumer.
- One clock, one output register stage, full throughput of one word per cycle.

---
 rtl/tdm_mux16_if.sv | 34 +++
 rtl/tdm_mux16.sv | 101 ++++++++++
 2 files changed

// File: rtl/tdm_mux16_if.sv
// tdm_mux16_if: lane-side and output-side signals of the 16-to-1 TDM collector.
// Ports: lane_data/lane_valid/lane_ack (16 producers), out_data/out_sel/out_valid/out_ready (consumer).
// Modports: slave = the multiplexer itself, master = the environment driving lanes and out_ready.
interface tdm_mux16_if #(
  parameter int DW = 5
);
  logic [16*DW-1:0] lane_data;
  logic [15:0]      lane_valid;
  logic [15:0]      lane_ack;
  logic [DW-1:0]    out_data;
  logic [3:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  lane_data,
    input  lane_valid,
    input  out_ready,
    output lane_ack,
    output out_data,
    output out_sel,
    output out_valid
  );

  modport master (
    output lane_data,
    output lane_valid,
    output out_ready,
    input  lane_ack,
    input  out_data,
    input  out_sel,
    input  out_valid
  );
endinterface

// File: rtl/tdm_mux16.sv
// tdm_mux16: round-robin 16-lane to 1 collector with a single registered output stage.
// Latency: 1 cycle from lane_valid (output able to load) to out_valid; one word per cycle sustained.
// Backpressure: out_ready=0 while full holds out_data/out_sel and forces lane_ack to zero.
// Ports: clk, rst_n (async active-low), bus (tdm_mux16_if.slave), xfer_cnt (only with TDM_MUX_STAT_EN).
// Optional feature macro: TDM_MUX_STAT_EN adds a saturating 16-bit output transfer counter.
module tdm_mux16 #(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  tdm_mux16_if.slave    bus
`ifdef TDM_MUX_STAT_EN
  ,
  output logic [15:0]   xfer_cnt
`endif
);

  // Output register occupancy doubles as the EMPTY/FULL state.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [3:0]    out_sel_q, out_sel_d;
  logic [3:0]    ptr_q, ptr_d;

  logic          gnt_vld;
  logic [3:0]    gnt_idx;
  logic [3:0]    scan_idx;
  logic          can_load;
  logic          load;

  // Rotating-priority search starting at ptr_q; 4-bit add wraps naturally.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = 4'd0;
    scan_idx = 4'd0;
    for (int k = 0; k < 16; k++) begin
      scan_idx = ptr_q + 4'(k);
      if (!gnt_vld && bus.lane_valid[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // rst_n gates the load so no lane is acked while reset is held.
  assign can_load = (state_q == ST_EMPTY) || bus.out_ready;
  assign load     = rst_n && gnt_vld && can_load;

  assign bus.lane_ack = load ? (16'h0001 << gnt_idx) : 16'h0000;

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ptr_d      = ptr_q;
    if (load) begin
      state_d    = ST_FULL;
      out_data_d = bus.lane_data[gnt_idx*DW +: DW];
      out_sel_d  = gnt_idx;
      ptr_d      = gnt_idx + 4'd1;
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= 4'd0;
      ptr_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef TDM_MUX_STAT_EN
  logic [15:0] xfer_cnt_q;

  // Counts accepted output words; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 16'h0000;
    end else if (bus.out_valid && bus.out_ready && (xfer_cnt_q != 16'hFFFF)) begin
      xfer_cnt_q <= xfer_cnt_q + 16'h0001;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
